// File: rtl/marquee_ctrl.sv
// marquee_ctrl -- LED marquee sequencer.
//
// Picks one tap of the free-running divider bus (TAP_BASE+speed) and turns
// its rising edges into step strobes. A run/pause/idle FSM rotates or
// bounces the LED pattern once per step.
//
// Ports:
//   clk       system clock (same clock as the divider)
//   rst       synchronous active-low reset
//   clk_div   32-bit divider count bus
//   speed     tap select, 0 = fastest
//   mode      00 rotl, 01 rotr, 10 bounce, 11 hold
//   start     load seed (0 -> 1) and run
//   stop      return to idle, wins over start
//   pause     level, freezes pattern while high
//   seed      initial pattern
//   led       current pattern
//   running   high in RUN or PAUSE
//   step      one-cycle strobe, aligned with the first cycle of a new led
//   dir       bounce direction, 0 = toward MSB
//   step_cnt  applied steps since last start
//
// Build option: define MARQUEE_STEP_CNT_EN to build the 16-bit step
// counter; otherwise step_cnt is tied to zero.
module marquee_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TAP_BASE = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      clk_div,
  input  logic [1:0]       speed,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] led,
  output logic             running,
  output logic             step,
  output logic             dir,
  output logic [15:0]      step_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state, state_nxt;
  logic [4:0]       tap_idx;
  logic             tap, tap_q, tap_edge;
  logic [1:0]       speed_q;
  logic [WIDTH-1:0] led_nxt, rotl, rotr;
  logic             dir_nxt, do_step;

  assign tap_idx = 5'(TAP_BASE) + 5'(speed);
  assign tap     = clk_div[tap_idx];
  // A speed change swaps taps; the new tap may already be high while tap_q
  // holds the old tap, so the edge is masked for that one cycle.
  assign tap_edge = tap & ~tap_q & (speed == speed_q);

  assign rotl    = {led[WIDTH-2:0], led[WIDTH-1]};
  assign rotr    = {led[0], led[WIDTH-1:1]};
  assign running = (state != IDLE);

  always_comb begin
    state_nxt = state;
    led_nxt   = led;
    dir_nxt   = dir;
    do_step   = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      led_nxt   = '0;
      dir_nxt   = 1'b0;
    end else if (start) begin
      state_nxt = RUN;
      led_nxt   = (seed == '0) ? WIDTH'(1) : seed;
      dir_nxt   = 1'b0;
    end else if (state == RUN && pause) begin
      state_nxt = PAUSE;
    end else if (state == PAUSE && !pause) begin
      state_nxt = RUN;
    end else if (state == RUN && tap_edge) begin
      // Edges outside RUN are dropped on purpose, never queued.
      do_step = 1'b1;
      case (mode)
        2'b00: led_nxt = rotl;
        2'b01: led_nxt = rotr;
        2'b10: begin
          if (!dir && led[WIDTH-1]) begin
            dir_nxt = 1'b1;
            led_nxt = rotr;
          end else if (dir && led[0]) begin
            dir_nxt = 1'b0;
            led_nxt = rotl;
          end else begin
            led_nxt = dir ? rotr : rotl;
          end
        end
        default: led_nxt = led;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      led     <= '0;
      dir     <= 1'b0;
      step    <= 1'b0;
      tap_q   <= 1'b0;
      speed_q <= 2'b0;
    end else begin
      state   <= state_nxt;
      led     <= led_nxt;
      dir     <= dir_nxt;
      step    <= do_step;
      tap_q   <= tap;
      speed_q <= speed;
    end
  end

`ifdef MARQUEE_STEP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst || start || stop) step_cnt <= '0;
    else if (do_step)          step_cnt <= step_cnt + 16'd1;
  end
`else
  assign step_cnt = '0;
`endif

endmodule

// File: doc/marquee_ctrl.md
# marquee_ctrl

Sequencer for the LED marquee. Consumes the free-running 32-bit divider bus from the clock divider, selects one divider tap by a speed setting, turns rising edges of that tap into single-cycle step strobes, and runs a run/pause/idle state machine that rotates or bounces an LED pattern once per step. It sits between the divider and the board LED outputs.

## Interface
- `WIDTH`, 8: number of LEDs (pattern width), 2..32.
- `TAP_BASE`, 22: divider bit used when `speed`=0. Tap index is `TAP_BASE+speed`. `TAP_BASE+3` must be ≤31.

- `clk` in 1: system clock, same clock as the divider.
- `rst` in 1: synchronous, active-low reset.
- `clk_div` in 32: divider count bus.
- `speed` in 2: tap select, 0 = fastest.
- `mode` in 2: 00 rotate left, 01 rotate right, 10 bounce, 11 hold.
- `start` in 1: load `seed` and run; sampled every cycle.
- `stop` in 1: return to idle; sampled every cycle.
- `pause` in 1: level; freezes pattern while high.
- `seed` in WIDTH: initial pattern.
- `led` out WIDTH: current pattern.
- `running` out 1: high in RUN or PAUSE.
- `step` out 1: one-cycle strobe, high in the first cycle a stepped `led` value is visible.
- `dir` out 1: bounce direction, 0 = left (toward MSB), 1 = right.
- `step_cnt` out 16: steps taken since last start (see Configuration).

## Operation
- Tap select: `tap = clk_div[TAP_BASE+speed]`. Register `tap_q <= tap` every cycle. Define `edge = tap & ~tap_q`.
- Speed change: when `speed` differs from its registered copy, suppress `edge` for that cycle. `tap_q` still loads the new tap value, so no spurious step is produced.
- States:
  - IDLE: `led`=0, `running`=0.
  - RUN: `running`=1.
  - PAUSE: `running`=1, `led` frozen.
- Transitions, by priority (highest first):
  1. `stop`=1: go to IDLE, `led`←0, `dir`←0. This applies from any state and overrides `start`.
  2. `start`=1: go to RUN, `led`←`seed`, or `led`←1 if `seed`=0. Also `dir`←0. This applies from any state, so a start during RUN or PAUSE restarts the pattern.
  3. RUN with `pause`=1: go to PAUSE.
  4. PAUSE with `pause`=0: go to RUN.
- Edges in IDLE or PAUSE are discarded, not queued.
- Step, applied only in RUN with `pause`=0 and no `start` or `stop` that cycle, when `edge`=1:
  - mode 00: `led`←{`led`[W-2:0], `led`[W-1]}.
  - mode 01: `led`←{`led`[0], `led`[W-1:1]}.
  - mode 10, `dir`=0 and `led`[W-1]=1: set `dir`←1 and rotate right.
  - mode 10, `dir`=1 and `led`[0]=1: set `dir`←0 and rotate left.
  - mode 10, otherwise: rotate in the current `dir`.
  - mode 11: `led` unchanged, but `step` still pulses.
- Rotation never loses bits; the popcount of `led` is invariant while running.
- `mode` change takes effect on the next step. `dir` is retained across a mode change.

## Timing
- Reset (`rst`=0 at a rising edge):
  - `led`=0, `running`=0, `step`=0, `dir`=0, `step_cnt`=0.
  - `tap_q`←0, speed register←0, state IDLE.
- Start latency: `start` high at edge k gives `led`=`seed` and `running`=1 after edge k.
- Step latency: the tap rises between edges k-1 and k; `led` updates at edge k, and `step`=1 for the cycle following edge k.
- Step period: 2^(TAP_BASE+speed+1) clocks in steady state.
- Stop latency: one edge. `led`=0 and `running`=0 after the edge at which `stop`=1.
- Simultaneous events:
  - start and edge in the same cycle: load only, no step, `step`=0.
  - pause and edge in the same cycle: no step.
- Reset mid-run behaves as a reset; no partial step.

## Configuration
- `MARQUEE_STEP_CNT_EN` defined:
  - 16-bit `step_cnt` increments on each applied step, including mode 11.
  - Clears on `start`, `stop` and reset.
  - Wraps 0xFFFF→0x0000.
- `MARQUEE_STEP_CNT_EN` undefined: `step_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Reset and start:
  - Stimulus: `rst`=0 for 2 cycles, then `WIDTH`=8, `TAP_BASE`=2, `speed`=0, `seed`=0x01, one-cycle `start`.
  - Required: all outputs 0 during reset. `led`=0x01 and `running`=1 the cycle after `start`.
- Rotate left:
  - Stimulus: `mode`=00, 8 steps, step period 8 clocks.
  - Required: `led` sequence 0x02, 0x04 … 0x80, 0x01, with `step` high exactly one cycle per change.
- Bounce:
  - Stimulus: `mode`=10, `seed`=0x40.
  - Required: `led` 0x80, then 0x40 with `dir`=1, …, down to 0x01, then 0x02 with `dir`=0.
- Speed change:
  - Stimulus: switch `speed` 0→3 mid-run.
  - Required: no step in the switch cycle, then step period 64 clocks.
- Pause, start and stop interaction:
  - Stimulus: `pause` high for 40 clocks.
  - Required: `led` frozen and `running`=1. Asserting `start` and `stop` together gives `led`=0, `running`=0.
- Step counter (with `MARQUEE_STEP_CNT_EN`):
  - Required: `step_cnt` reaches 5 after 5 steps and clears to 0 on a restart.
  - Stimulus: force 65536 steps.
  - Required: wraps to 0.
